// File: rtl/dot_product_fp16_pkg.sv
// Shared constants and types for the fp16 dot-product stack and its input feeder.
package dot_product_fp16_pkg;

  localparam int unsigned K_DEF     = 4;
  localparam int unsigned B_DEF     = 2;
  localparam int unsigned FP_DEF    = 16;
  localparam int unsigned LANES_DEF = K_DEF * B_DEF;
  localparam int unsigned LW_DEF    = $clog2(LANES_DEF + 1);

  localparam logic [15:0] FP16_ZERO = 16'h0000;

  typedef logic [LW_DEF-1:0] lane_cnt_t;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StPad
  } state_e;

endpackage

// File: rtl/fp16_lane_mask.sv
// Zeroes every lane at index >= n_i; n_i == 0 keeps all lanes.
module fp16_lane_mask
  import dot_product_fp16_pkg::*;
#(
  parameter int unsigned Lanes = 8,
  parameter int unsigned FP    = 16,
  parameter int unsigned LW    = 4
) (
  input  logic [Lanes*FP-1:0] lanes_i,
  input  logic [LW-1:0]       n_i,
  output logic [Lanes*FP-1:0] lanes_o
);

  for (genvar l = 0; l < Lanes; l++) begin : g_lane
    assign lanes_o[l*FP +: FP] = ((n_i == '0) || (32'(l) < 32'(n_i))) ? lanes_i[l*FP +: FP]
                                                                       : FP'(FP16_ZERO);
  end

endmodule

// File: rtl/dot_product_fp16_feeder.sv
// Feeds the fp16 dot-product stack: masks tail lanes, pads short vectors with zero beats,
// and guarantees every cycle between first and last carries data or zeros.
module dot_product_fp16_feeder
  import dot_product_fp16_pkg::*;
#(
  parameter int unsigned K         = K_DEF,
  parameter int unsigned B         = B_DEF,
  parameter int unsigned FP        = FP_DEF,
  parameter int unsigned MIN_BEATS = 2,
  parameter int unsigned LW        = $clog2(K * B + 1)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [K*B*FP-1:0]  i_a,
  input  logic [K*B*FP-1:0]  i_b,
  input  logic               i_last,
  input  logic [LW-1:0]      i_lanes,
  output logic [K*B*FP-1:0]  o_a,
  output logic [K*B*FP-1:0]  o_b,
  output logic               o_first,
  output logic               o_last,
  output logic               o_busy,
  output logic [15:0]        o_vec_count
);

  localparam int unsigned Lanes = K * B;
  localparam int unsigned W     = Lanes * FP;
  localparam int unsigned BW    = $clog2(MIN_BEATS + 1);
  localparam logic [BW:0] MinBeats = (BW + 1)'(MIN_BEATS);

  state_e          state_q, state_d;
  logic [BW-1:0]   bcnt_q, bcnt_d, bcnt_inc;
  logic [W-1:0]    a_q, a_d, b_q, b_d, a_masked, b_masked;
  logic            first_q, first_d, last_q, last_d, busy_q, busy_d, ready_q, ready_d;
  logic [15:0]     count_q, count_d;
  logic            accept, min_met, issue_last;
  logic [LW-1:0]   mask_n;

  assign accept = i_valid & ready_q;
  // Lane count only applies to the final beat; 0 means all lanes.
  assign mask_n = i_last ? i_lanes : '0;

  fp16_lane_mask #(.Lanes(Lanes), .FP(FP), .LW(LW)) u_mask_a (
    .lanes_i (i_a),
    .n_i     (mask_n),
    .lanes_o (a_masked)
  );

  fp16_lane_mask #(.Lanes(Lanes), .FP(FP), .LW(LW)) u_mask_b (
    .lanes_i (i_b),
    .n_i     (mask_n),
    .lanes_o (b_masked)
  );

  assign min_met  = (({1'b0, bcnt_q} + 1'b1) >= MinBeats);
  assign bcnt_inc = min_met ? MinBeats[BW-1:0] : bcnt_q + BW'(1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
      bcnt_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      first_q <= first_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    issue_last = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          bcnt_d = BW'(1);
          if (i_last && (MIN_BEATS == 1)) begin
            issue_last = 1'b1;
          end else if (i_last) begin
            state_d = StPad;
          end else begin
            state_d = StActive;
          end
        end
      end
      StActive: begin
        // Gaps leave bcnt alone; only issued data beats count toward the minimum.
        if (accept) begin
          bcnt_d = bcnt_inc;
          if (i_last && min_met) begin
            issue_last = 1'b1;
            state_d    = StIdle;
          end else if (i_last) begin
            state_d = StPad;
          end
        end
      end
      StPad: begin
        bcnt_d = bcnt_inc;
        if (min_met) begin
          issue_last = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    a_d     = accept ? a_masked : '0;
    b_d     = accept ? b_masked : '0;
    first_d = accept && (state_q == StIdle);
    last_d  = issue_last;
    busy_d  = (state_d != StIdle);
    ready_d = (state_d != StPad);
    count_d = count_q + 16'(issue_last);
  end

  assign o_a         = a_q;
  assign o_b         = b_q;
  assign o_first     = first_q;
  assign o_last      = last_q;
  assign o_busy      = busy_q;
  assign o_ready     = ready_q;
  assign o_vec_count = count_q;

endmodule

// File: tb/tb_dot_product_fp16_feeder.sv
// Bench for dot_product_fp16_feeder: table-driven scoreboard on a MIN_BEATS=2 instance,
// hand-written single-beat and counter-wrap sequences on a MIN_BEATS=1 instance.
module tb_dot_product_fp16_feeder;
  import dot_product_fp16_pkg::*;

  localparam int W = 128;

  typedef struct {
    logic        rst;
    logic        valid;
    logic        last;
    lane_cnt_t   lanes;
    logic [15:0] a_val;
    logic [15:0] b_val;
    logic [15:0] stride;
    int          exp_n;
    logic        exp_first;
    logic        exp_last;
    logic        exp_ready;
    logic        exp_busy;
    logic [15:0] exp_count;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst0, v0, l0, rdy0, f0o, l0o, busy0;
  logic [3:0]   lanes0;
  logic [W-1:0] a0, b0, oa0, ob0;
  logic [15:0]  cnt0;

  logic         rst1, v1, l1, rdy1, f1o, l1o, busy1;
  logic [3:0]   lanes1;
  logic [W-1:0] a1, b1, oa1, ob1;
  logic [15:0]  cnt1;

  int n_checks = 0;
  int n_errors = 0;

  dot_product_fp16_feeder #(.MIN_BEATS(2)) u_dut0 (
    .i_clk (clk), .i_reset (rst0), .i_valid (v0), .o_ready (rdy0),
    .i_a (a0), .i_b (b0), .i_last (l0), .i_lanes (lanes0),
    .o_a (oa0), .o_b (ob0), .o_first (f0o), .o_last (l0o), .o_busy (busy0),
    .o_vec_count (cnt0)
  );

  dot_product_fp16_feeder #(.MIN_BEATS(1)) u_dut1 (
    .i_clk (clk), .i_reset (rst1), .i_valid (v1), .o_ready (rdy1),
    .i_a (a1), .i_b (b1), .i_last (l1), .i_lanes (lanes1),
    .o_a (oa1), .o_b (ob1), .o_first (f1o), .o_last (l1o), .o_busy (busy1),
    .o_vec_count (cnt1)
  );

  function automatic logic [W-1:0] pat(input logic [15:0] base, input logic [15:0] stride,
                                       input int n);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i*16 +: 16] = (i < n) ? base + stride * 16'(i) : 16'h0000;
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic rst, input logic valid, input logic last,
                              input int lanes, input logic [15:0] a_val,
                              input logic [15:0] b_val, input logic [15:0] stride,
                              input int exp_n, input logic ef, input logic el,
                              input logic er, input logic eb, input int ec);
    vec_t v;
    v.rst = rst; v.valid = valid; v.last = last; v.lanes = lane_cnt_t'(lanes);
    v.a_val = a_val; v.b_val = b_val; v.stride = stride; v.exp_n = exp_n;
    v.exp_first = ef; v.exp_last = el; v.exp_ready = er; v.exp_busy = eb;
    v.exp_count = 16'(ec);
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare0(input vec_t e, input int step);
    check($sformatf("s%0d o_a", step), oa0, pat(e.a_val, e.stride, e.exp_n));
    check($sformatf("s%0d o_b", step), ob0, pat(e.b_val, e.stride, e.exp_n));
    check($sformatf("s%0d o_first", step), W'(f0o), W'(e.exp_first));
    check($sformatf("s%0d o_last", step), W'(l0o), W'(e.exp_last));
    check($sformatf("s%0d o_ready", step), W'(rdy0), W'(e.exp_ready));
    check($sformatf("s%0d o_busy", step), W'(busy0), W'(e.exp_busy));
    check($sformatf("s%0d o_vec_count", step), W'(cnt0), W'(e.exp_count));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  vec_t tbl[$];
  vec_t sb[$];
  int   sb_step[$];

  initial begin
    // rst valid last lanes a b stride | n first last ready busy count
    tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 0, 0));
    // Full vector of 1.0, three beats
    tbl.push_back(mk(0, 1, 0, 0, 16'h3C00, 16'h3C00, 0, 8, 1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 16'h3C00, 16'h3C00, 0, 8, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 16'h3C00, 16'h3C00, 0, 8, 0, 1, 1, 0, 1));
    // Gap mid-vector
    tbl.push_back(mk(0, 1, 0, 0, 16'h1000, 16'h2000, 1, 8, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 16'h1111, 16'h1111, 1, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 16'h1111, 16'h1111, 1, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 1, 8, 16'h4000, 16'h4400, 1, 8, 0, 1, 1, 0, 2));
    // Short vector: NaN / -0.0 data, lanes=3, then pad (valid ignored while not ready)
    tbl.push_back(mk(0, 1, 1, 3, 16'h7E00, 16'h8000, 1, 3, 1, 0, 0, 1, 2));
    tbl.push_back(mk(0, 1, 0, 0, 16'h1111, 16'h1111, 0, 0, 0, 1, 1, 0, 3));
    // Two-beat vector masked to 5, then back-to-back first beat
    tbl.push_back(mk(0, 1, 0, 0, 16'h2222, 16'h2A00, 1, 8, 1, 0, 1, 1, 3));
    tbl.push_back(mk(0, 1, 1, 5, 16'h3333, 16'h3B00, 1, 5, 0, 1, 1, 0, 4));
    tbl.push_back(mk(0, 1, 0, 0, 16'h4444, 16'h4C00, 1, 8, 1, 0, 1, 1, 4));
    tbl.push_back(mk(0, 1, 0, 3, 16'h5555, 16'h5D00, 1, 8, 0, 0, 1, 1, 4));
    // Reset mid-vector, then a clean single-beat vector padded to two
    tbl.push_back(mk(1, 1, 1, 0, 16'h6666, 16'h6666, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 16'h6000, 16'h6800, 2, 8, 1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 0, 1));
    // Last beat with a single lane
    tbl.push_back(mk(0, 1, 0, 0, 16'h0100, 16'h0200, 3, 8, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, 1, 1, 1, 16'h0300, 16'h0400, 3, 1, 0, 1, 1, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 0, 2));

    rst0 = 1'b1; v0 = 1'b0; l0 = 1'b0; lanes0 = '0; a0 = '0; b0 = '0;
    rst1 = 1'b1; v1 = 1'b0; l1 = 1'b0; lanes1 = '0; a1 = '0; b1 = '0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      if (sb.size() > 0) compare0(sb.pop_front(), sb_step.pop_front());
      rst0   = tbl[i].rst;
      v0     = tbl[i].valid;
      l0     = tbl[i].last;
      lanes0 = tbl[i].lanes;
      a0     = pat(tbl[i].a_val, tbl[i].stride, 8);
      b0     = pat(tbl[i].b_val, tbl[i].stride, 8);
      sb.push_back(tbl[i]);
      sb_step.push_back(i);
    end
    @(negedge clk);
    while (sb.size() > 0) compare0(sb.pop_front(), sb_step.pop_front());
    v0 = 1'b0;

    // MIN_BEATS=1: single-beat vectors carry first and last together
    @(negedge clk);
    rst1 = 1'b0;
    @(negedge clk);
    check("m1 ready after reset", W'(rdy1), W'(1'b1));
    v1 = 1'b1; l1 = 1'b1; lanes1 = 4'd2; a1 = pat(16'h3C00, 16'h0001, 8);
    b1 = pat(16'hBC00, 16'h0001, 8);
    @(negedge clk);
    check("m1 v1 o_a", oa1, pat(16'h3C00, 16'h0001, 2));
    check("m1 v1 o_b", ob1, pat(16'hBC00, 16'h0001, 2));
    check("m1 v1 first", W'(f1o), W'(1'b1));
    check("m1 v1 last", W'(l1o), W'(1'b1));
    check("m1 v1 count", W'(cnt1), W'(16'd1));
    lanes1 = 4'd0; a1 = pat(16'h4000, 16'h0000, 8);
    @(negedge clk);
    check("m1 v2 o_a", oa1, pat(16'h4000, 16'h0000, 8));
    check("m1 v2 first", W'(f1o), W'(1'b1));
    check("m1 v2 last", W'(l1o), W'(1'b1));
    check("m1 v2 busy", W'(busy1), W'(1'b0));
    check("m1 v2 count", W'(cnt1), W'(16'd2));

    // Keep issuing one vector per cycle until the counter wraps
    for (int i = 0; i < 65533; i++) @(negedge clk);
    check("wrap count ffff", W'(cnt1), W'(16'hFFFF));
    @(negedge clk);
    check("wrap count 0", W'(cnt1), W'(16'h0000));
    v1 = 1'b0;
    @(negedge clk);
    check("idle after wrap last", W'(l1o), W'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
